// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue: splits fetched 32-bit words into Thumb halfwords and queues them for the decoder
module thumb_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     mem_req,
    output logic [ADDR_W-3:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    input  logic                     branch_valid,
    input  logic [ADDR_W-1:0]        branch_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [15:0]              instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_outstanding;
    logic              r_discard;
    logic              r_run;
    logic [15:0]       r_hw [DEPTH];
    logic [ADDR_W-1:0] r_pc [DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_occ;
    logic              w_pop;
    logic              w_push1;
    logic              w_push2;
    logic              w_grant;
    logic [CW-1:0]     w_free;
    logic [CW-1:0]     w_push_n;

    assign instr_valid = r_occ != '0;
    assign instr       = r_hw[r_rd];
    assign instr_pc    = r_pc[r_rd];
    assign occupancy   = r_occ;
    assign w_pop       = instr_valid & instr_ready & ~branch_valid;
    assign w_push1     = mem_rvalid & r_outstanding & ~r_discard & ~branch_valid;
    assign w_push2     = w_push1 & ~r_req_pc[1];
    assign w_push_n    = CW'(w_push1) + CW'(w_push2);
    assign w_free      = CW'(DEPTH) - r_occ + CW'(w_pop);
    // a word may yield two halfwords, so only fetch when two slots are free
    assign mem_req     = r_run & ~r_outstanding & ~branch_valid & (w_free >= CW'(2));
    assign mem_addr    = r_fetch_pc[ADDR_W-1:2];
    assign w_grant     = mem_req & mem_gnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC & ~ADDR_W'(1);
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_occ         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hw[i] <= '0;
                r_pc[i] <= '0;
            end
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_grant | (r_outstanding & ~mem_rvalid);
            // a response landing in the redirect cycle is dropped there, so no discard is needed
            r_discard     <= r_outstanding & ~mem_rvalid & (r_discard | branch_valid);
            if (w_grant)
                r_req_pc <= r_fetch_pc;
            if (branch_valid)
                r_fetch_pc <= branch_target & ~ADDR_W'(1);
            else if (w_grant)
                r_fetch_pc <= {r_fetch_pc[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
            if (w_push1) begin
                r_hw[r_wr] <= r_req_pc[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                r_pc[r_wr] <= r_req_pc;
            end
            if (w_push2) begin
                r_hw[r_wr + PW'(1)] <= mem_rdata[31:16];
                r_pc[r_wr + PW'(1)] <= r_req_pc + ADDR_W'(2);
            end
            if (branch_valid) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_occ <= '0;
            end else begin
                r_rd  <= r_rd + PW'(w_pop);
                r_wr  <= r_wr + PW'(w_push_n);
                r_occ <= r_occ + w_push_n - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_thumb_fetch_queue.sv
// tb_thumb_fetch_queue: directed and random checks; the model is the sequential halfword stream of memory
module tb_thumb_fetch_queue;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] mem [256];
    logic [31:0] exp_pc = '0;
    bit          pend = 0;
    int          cnt = 0;
    logic [29:0] paddr = '0;
    int          lat = 1;
    bit          rand_gnt = 0;
    bit          rand_lat = 0;
    logic [15:0] pop_hw [$];
    logic [31:0] pop_pc [$];
    logic [29:0] gnt_log [$];

    thumb_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic clear_logs();
        pop_hw.delete();
        pop_pc.delete();
        gnt_log.delete();
    endtask

    // memory side of the cycle, then let combinational outputs settle
    task automatic pre();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend       = 0;
                mem_rvalid = 1'b1;
                mem_rdata  = mem[paddr[7:0]];
            end
        end
        mem_gnt = rand_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
    endtask

    task automatic post();
        n_assert++;
        if (occupancy > DEPTH) begin
            n_fail++;
            $display("FAIL overflow occupancy=%0d limit=%0d", occupancy, DEPTH);
        end
        n_assert++;
        if (mem_req && (pend || branch_valid)) begin
            n_fail++;
            $display("FAIL req_rule mem_req=%b while pending=%b branch=%b, want 0", mem_req, pend, branch_valid);
        end
        if (instr_valid && instr_ready && !branch_valid) begin
            n_assert += 2;
            if (instr_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL pop_pc got %h want %h", instr_pc, exp_pc);
            end
            if (instr !== hw_at(exp_pc)) begin
                n_fail++;
                $display("FAIL pop_hw at %h got %h want %h", exp_pc, instr, hw_at(exp_pc));
            end
            pop_hw.push_back(instr);
            pop_pc.push_back(instr_pc);
            exp_pc += 2;
        end
        if (branch_valid) exp_pc = branch_target & ~32'h1;
        if (mem_req && mem_gnt) begin
            gnt_log.push_back(mem_addr);
            pend  = 1;
            paddr = mem_addr;
            cnt   = rand_lat ? $urandom_range(1, 4) : lat;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_assert += 5;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", mem_req); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        if (instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", instr); end
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        reset_n = 1'b1;
        exp_pc  = RESET_PC & ~32'h1;
        pend    = 0;
    endtask

    task automatic test_basic();
        bit ok;
        instr_ready = 1'b1;
        lat = 1;
        clear_logs();
        for (int i = 0; i < 40 && !(pop_pc.size() >= 2 && gnt_log.size() >= 2); i++) begin pre(); post(); end
        ok = pop_pc.size() >= 2 && gnt_log.size() >= 2;
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout pops=%0d grants=%0d want 2/2", pop_pc.size(), gnt_log.size()); end
        else begin
            n_assert += 6;
            if (pop_hw[0] !== 16'h2003) begin n_fail++; $display("FAIL basic_hw0 got %h want 2003", pop_hw[0]); end
            if (pop_pc[0] !== 32'h0) begin n_fail++; $display("FAIL basic_pc0 got %h want 0", pop_pc[0]); end
            if (pop_hw[1] !== 16'h2105) begin n_fail++; $display("FAIL basic_hw1 got %h want 2105", pop_hw[1]); end
            if (pop_pc[1] !== 32'h2) begin n_fail++; $display("FAIL basic_pc1 got %h want 2", pop_pc[1]); end
            if (gnt_log[0] !== 30'd0) begin n_fail++; $display("FAIL basic_addr0 got %h want 0", gnt_log[0]); end
            if (gnt_log[1] !== 30'd1) begin n_fail++; $display("FAIL basic_addr1 got %h want 1", gnt_log[1]); end
        end
    endtask

    task automatic test_odd_branch();
        bit ok;
        clear_logs();
        branch_valid = 1'b1; branch_target = 32'h6;
        pre(); post();
        branch_valid = 1'b0;
        n_assert += 2;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL odd_flush_occ got %0d want 0", occupancy); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL odd_flush_valid got %b want 0", instr_valid); end
        for (int i = 0; i < 40 && !(pop_pc.size() >= 1 && gnt_log.size() >= 2); i++) begin pre(); post(); end
        ok = pop_pc.size() >= 1 && gnt_log.size() >= 2;
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL odd_timeout pops=%0d grants=%0d want 1/2", pop_pc.size(), gnt_log.size()); end
        else begin
            n_assert += 4;
            if (pop_hw[0] !== 16'hE7FE) begin n_fail++; $display("FAIL odd_hw got %h want e7fe", pop_hw[0]); end
            if (pop_pc[0] !== 32'h6) begin n_fail++; $display("FAIL odd_pc got %h want 6", pop_pc[0]); end
            if (gnt_log[0] !== 30'd1) begin n_fail++; $display("FAIL odd_addr0 got %h want 1", gnt_log[0]); end
            if (gnt_log[1] !== 30'd2) begin n_fail++; $display("FAIL odd_addr1 got %h want 2", gnt_log[1]); end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        branch_valid = 1'b1; branch_target = 32'h100;
        pre(); post();
        branch_valid = 1'b0;
        repeat (15) begin pre(); post(); end
        pre();
        n_assert += 2;
        if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_full_occ got %0d want 4", occupancy); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req got %b want 0", mem_req); end
        instr_ready = 1'b1;
        #1;
        n_assert++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_pop1_req got %b want 0", mem_req); end
        post();
        instr_ready = 1'b0;
        pre();
        n_assert += 2;
        if (occupancy !== 3'd3) begin n_fail++; $display("FAIL bp_occ3 got %0d want 3", occupancy); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_occ3_req got %b want 0", mem_req); end
        instr_ready = 1'b1;
        #1;
        n_assert++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL bp_pop2_req got %b want 1", mem_req); end
        post();
    endtask

    task automatic test_push_pop();
        int  st;
        bit  found;
        lat = 3;
        instr_ready = 1'b0;
        branch_valid = 1'b1; branch_target = 32'h80;
        pre(); post();
        branch_valid = 1'b0;
        st = 0;
        for (int i = 0; i < 60 && st < 2; i++) begin
            pre();
            if (st == 0 && occupancy == 3'd2) begin instr_ready = 1'b1; st = 1; #1; end
            else if (st == 1 && mem_rvalid && occupancy == 3'd1) begin instr_ready = 1'b1; st = 2; #1; end
            post();
            instr_ready = 1'b0;
        end
        n_assert += 2;
        if (st != 2) begin n_fail++; $display("FAIL pp_timeout stage=%0d want 2", st); end
        if (occupancy !== 3'd2) begin n_fail++; $display("FAIL pp_occ got %0d want 2", occupancy); end
        instr_ready = 1'b1;
        repeat (8) begin pre(); post(); end
        instr_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (mem_rvalid && instr_valid) begin
                found = 1;
                instr_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'hC0;
                #1;
            end
            post();
            branch_valid = 1'b0;
            instr_ready = 1'b0;
        end
        n_assert += 3;
        if (!found) begin n_fail++; $display("FAIL pp_redir_timeout found=0 want 1"); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL pp_redir_occ got %0d want 0", occupancy); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL pp_redir_valid got %b want 0", instr_valid); end
        instr_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 40 && pop_pc.size() < 1; i++) begin pre(); post(); end
        n_assert++;
        if (pop_pc.size() < 1) begin n_fail++; $display("FAIL pp_after_timeout pops=0 want 1"); end
        else begin
            n_assert++;
            if (pop_pc[0] !== 32'hC0) begin n_fail++; $display("FAIL pp_after_pc got %h want c0", pop_pc[0]); end
        end
    endtask

    task automatic test_redirect_rvalid();
        bit found;
        lat = 3;
        instr_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (mem_rvalid) begin
                found = 1;
                branch_valid = 1'b1; branch_target = 32'h40;
                #1;
            end
            post();
            branch_valid = 1'b0;
        end
        n_assert += 2;
        if (!found) begin n_fail++; $display("FAIL rr_timeout found=0 want 1"); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rr_occ got %0d want 0", occupancy); end
        clear_logs();
        for (int i = 0; i < 40 && pop_pc.size() < 1; i++) begin pre(); post(); end
        n_assert++;
        if (pop_pc.size() < 1) begin n_fail++; $display("FAIL rr_pop_timeout pops=0 want 1"); end
        else begin
            n_assert++;
            if (pop_pc[0] !== 32'h40) begin n_fail++; $display("FAIL rr_first_pc got %h want 40", pop_pc[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 5;
        instr_ready = 1'b1;
        branch_valid = 1'b1; branch_target = 32'h100;
        pre(); post();
        branch_valid = 1'b0;
        clear_logs();
        for (int i = 0; i < 40 && gnt_log.size() < 1; i++) begin pre(); post(); end
        reset_n = 1'b0;
        pend = 0;
        #1;
        n_assert += 4;
        if (gnt_log.size() < 1) begin n_fail++; $display("FAIL rm_grant_timeout grants=0 want 1"); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req got %b want 0", mem_req); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rm_occ got %0d want 0", occupancy); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", instr_valid); end
        pre(); post();
        reset_n = 1'b1;
        exp_pc  = RESET_PC & ~32'h1;
        pend = 1; cnt = 1; paddr = 30'd7;
        clear_logs();
        for (int i = 0; i < 40 && !(pop_pc.size() >= 1 && gnt_log.size() >= 1); i++) begin pre(); post(); end
        ok = pop_pc.size() >= 1 && gnt_log.size() >= 1;
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL rm_timeout pops=%0d grants=%0d want 1/1", pop_pc.size(), gnt_log.size()); end
        else begin
            n_assert += 3;
            if (gnt_log[0] !== 30'd0) begin n_fail++; $display("FAIL rm_addr got %h want 0", gnt_log[0]); end
            if (pop_pc[0] !== 32'h0) begin n_fail++; $display("FAIL rm_pc got %h want 0", pop_pc[0]); end
            if (pop_hw[0] !== 16'h2003) begin n_fail++; $display("FAIL rm_hw got %h want 2003", pop_hw[0]); end
        end
    endtask

    task automatic test_random();
        int pops_before;
        rand_gnt = 1;
        rand_lat = 1;
        clear_logs();
        for (int i = 0; i < 1500; i++) begin
            instr_ready   = $urandom_range(0, 3) != 0;
            branch_valid  = $urandom_range(0, 39) == 0;
            branch_target = $urandom_range(0, 1023);
            pre(); post();
        end
        branch_valid = 1'b0;
        instr_ready  = 1'b1;
        repeat (30) begin pre(); post(); end
        pops_before = pop_pc.size();
        n_assert++;
        if (pops_before < 200) begin n_fail++; $display("FAIL rand_throughput pops=%0d want >=200", pops_before); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2105_2003;
        mem[1] = 32'hE7FE_BF00;
        test_reset();
        test_basic();
        test_odd_branch();
        test_backpressure();
        test_push_pop();
        test_redirect_rvalid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
